// File: rtl/sprite_pkg.sv
// +----------------------------------------------------------------------+
// | sprite_pkg : shared constants and types for the digit sprite fetch   |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
`default_nettype none

package sprite_pkg;
  localparam int SPRITE_W = 20;
  localparam int SPRITE_H = 20;
  localparam int SPRITE_ADDR_W = 10;
  localparam logic [7:0] KEY_COLOUR = 8'h00;

  // Scan-minus-position offset; 11 bits signed so 0..639 minus 0..639 never wraps.
  typedef logic signed [10:0] coord_off_t;
endpackage

`default_nettype wire

// File: rtl/sprite_pos_shadow.sv
// +----------------------------------------------------------------------+
// | sprite_pos_shadow : shadowed sprite position, applied at frame start |
// | Revision          : 1.0                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module sprite_pos_shadow #(
  parameter logic [9:0] RST_X = 10'd310,
  parameter logic [9:0] RST_Y = 10'd230
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_start,
  input  logic       pos_load,
  input  logic [9:0] req_x,
  input  logic [9:0] req_y,
  output logic [9:0] pos_x,
  output logic [9:0] pos_y
);

  logic [9:0] pend_x, pend_y;
  logic       pend;
  logic [9:0] pend_x_nxt, pend_y_nxt, pos_x_nxt, pos_y_nxt;
  logic       pend_nxt;

  // A load landing on the frame-start cycle bypasses the shadow entirely.
  always_comb begin
    pend_x_nxt = pend_x;
    pend_y_nxt = pend_y;
    pend_nxt   = pend;
    pos_x_nxt  = pos_x;
    pos_y_nxt  = pos_y;
    if (frame_start) begin
      pend_nxt = 1'b0;
      if (pos_load) begin
        pos_x_nxt = req_x;
        pos_y_nxt = req_y;
      end else if (pend) begin
        pos_x_nxt = pend_x;
        pos_y_nxt = pend_y;
      end
    end else if (pos_load) begin
      pend_x_nxt = req_x;
      pend_y_nxt = req_y;
      pend_nxt   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_x <= '0;
      pend_y <= '0;
      pend   <= 1'b0;
      pos_x  <= RST_X;
      pos_y  <= RST_Y;
    end else begin
      pend_x <= pend_x_nxt;
      pend_y <= pend_y_nxt;
      pend   <= pend_nxt;
      pos_x  <= pos_x_nxt;
      pos_y  <= pos_y_nxt;
    end
  end

endmodule

`default_nettype wire

// File: rtl/number_sprite_fetch.sv
// +----------------------------------------------------------------------+
// | number_sprite_fetch : digit ROM address generator and pixel stage    |
// | Revision            : 1.0                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module number_sprite_fetch #(
  parameter int         SPRITE_W = sprite_pkg::SPRITE_W,
  parameter int         SPRITE_H = sprite_pkg::SPRITE_H,
  parameter logic [7:0] KEY      = sprite_pkg::KEY_COLOUR,
  parameter logic [9:0] RST_X    = 10'd310,
  parameter logic [9:0] RST_Y    = 10'd230
) (
  input  logic       i_clk2,
  input  logic       i_rst_n,
  input  logic [9:0] i_x,
  input  logic [9:0] i_y,
  input  logic       i_active,
  input  logic       i_frame_start,
  input  logic [9:0] i_pos_x,
  input  logic [9:0] i_pos_y,
  input  logic       i_pos_load,
  output logic [9:0] o_numberaddr,
  input  logic [7:0] i_numberdata,
  output logic [7:0] o_pixel,
  output logic       o_pixel_valid
);

  import sprite_pkg::*;

  logic [9:0] pos_x, pos_y;

  sprite_pos_shadow #(
    .RST_X(RST_X),
    .RST_Y(RST_Y)
  ) u_pos_shadow (
    .clk        (i_clk2),
    .rst_n      (i_rst_n),
    .frame_start(i_frame_start),
    .pos_load   (i_pos_load),
    .req_x      (i_pos_x),
    .req_y      (i_pos_y),
    .pos_x      (pos_x),
    .pos_y      (pos_y)
  );

  coord_off_t                dx, dy;
  logic                      inbox_c;
  logic [SPRITE_ADDR_W-1:0]  addr_c;
  logic                      inbox, inbox_d;
  logic                      opaque;

  always_comb begin
    dx      = coord_off_t'({1'b0, i_x}) - coord_off_t'({1'b0, pos_x});
    dy      = coord_off_t'({1'b0, i_y}) - coord_off_t'({1'b0, pos_y});
    inbox_c = i_active && !dx[10] && !dy[10]
              && (dx < coord_off_t'(SPRITE_W)) && (dy < coord_off_t'(SPRITE_H));
    // dy*20 as two shifts; only meaningful (and <= 399) when inbox_c is set.
    addr_c  = (dy[9:0] << 4) + (dy[9:0] << 2) + dx[9:0];
    opaque  = (i_numberdata != KEY);
  end

  always_ff @(posedge i_clk2 or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_numberaddr  <= '0;
      inbox         <= 1'b0;
      inbox_d       <= 1'b0;
      o_pixel       <= '0;
      o_pixel_valid <= 1'b0;
    end else begin
      o_numberaddr  <= inbox_c ? addr_c : '0;
      inbox         <= inbox_c;
      inbox_d       <= inbox;
      o_pixel_valid <= inbox_d && opaque;
      o_pixel       <= (inbox_d && opaque) ? i_numberdata : 8'h00;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_number_sprite_fetch.sv
// +----------------------------------------------------------------------+
// | tb_number_sprite_fetch : directed bench with a behavioural digit ROM |
// | Revision               : 1.0                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_number_sprite_fetch;

  logic       clk;
  logic       rst_n;
  logic [9:0] x, y;
  logic       active;
  logic       frame_start;
  logic [9:0] pos_x_req, pos_y_req;
  logic       pos_load;
  logic [9:0] numberaddr;
  logic [7:0] numberdata;
  logic [7:0] pixel;
  logic       pixel_valid;

  int checks;
  int errors;

  number_sprite_fetch dut (
    .i_clk2       (clk),
    .i_rst_n      (rst_n),
    .i_x          (x),
    .i_y          (y),
    .i_active     (active),
    .i_frame_start(frame_start),
    .i_pos_x      (pos_x_req),
    .i_pos_y      (pos_y_req),
    .i_pos_load   (pos_load),
    .o_numberaddr (numberaddr),
    .i_numberdata (numberdata),
    .o_pixel      (pixel),
    .o_pixel_valid(pixel_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM content: address 5 holds the key colour, everything else low byte + 8'h3C.
  function automatic logic [7:0] rom_val(input logic [9:0] a);
    logic [7:0] lo;
    lo = a[7:0];
    if (a == 10'd5) return 8'h00;
    return lo + 8'h3C;
  endfunction

  always_ff @(posedge clk) numberdata <= rom_val(numberaddr);

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic       act;
    logic [9:0] addr;
    logic       vld;
    logic [7:0] pix;
  } vec_t;

  vec_t tbl[9];

  task automatic check(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act_v, exp_v);
    end
  endtask

  // Drive one coordinate, check address one cycle later and pixel three cycles later.
  task automatic run_vec(input string name, input logic [9:0] vx, input logic [9:0] vy,
                         input logic va, input logic [9:0] eaddr, input logic evld,
                         input logic [7:0] epix);
    @(negedge clk);
    x = vx; y = vy; active = va;
    @(negedge clk);
    check({name, ".addr"}, 32'(numberaddr), 32'(eaddr));
    x = '0; y = '0; active = 1'b0;
    repeat (2) @(negedge clk);
    check({name, ".valid"}, 32'(pixel_valid), 32'(evld));
    check({name, ".pixel"}, 32'(pixel), 32'(epix));
  endtask

  task automatic pulse_frame_start();
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic pulse_load(input logic [9:0] px, input logic [9:0] py, input logic with_fs);
    @(negedge clk);
    pos_x_req = px; pos_y_req = py; pos_load = 1'b1; frame_start = with_fs;
    @(negedge clk);
    pos_load = 1'b0; frame_start = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0; x = '0; y = '0; active = 1'b0; frame_start = 1'b0;
    pos_x_req = '0; pos_y_req = '0; pos_load = 1'b0;

    tbl[0] = '{10'd310, 10'd230, 1'b1, 10'd0,   1'b1, 8'h3C};
    tbl[1] = '{10'd329, 10'd249, 1'b1, 10'd399, 1'b1, 8'hCB};
    tbl[2] = '{10'd330, 10'd249, 1'b1, 10'd0,   1'b0, 8'h00};
    tbl[3] = '{10'd310, 10'd250, 1'b1, 10'd0,   1'b0, 8'h00};
    tbl[4] = '{10'd315, 10'd230, 1'b1, 10'd5,   1'b0, 8'h00};
    tbl[5] = '{10'd311, 10'd231, 1'b1, 10'd21,  1'b1, 8'h51};
    tbl[6] = '{10'd309, 10'd230, 1'b1, 10'd0,   1'b0, 8'h00};
    tbl[7] = '{10'd320, 10'd240, 1'b0, 10'd0,   1'b0, 8'h00};
    tbl[8] = '{10'd0,   10'd0,   1'b1, 10'd0,   1'b0, 8'h00};

    repeat (3) @(negedge clk);
    check("reset.addr",  32'(numberaddr),  32'd0);
    check("reset.valid", 32'(pixel_valid), 32'd0);
    check("reset.pixel", 32'(pixel),       32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++)
      run_vec($sformatf("vec%0d", i), tbl[i].x, tbl[i].y, tbl[i].act,
              tbl[i].addr, tbl[i].vld, tbl[i].pix);

    // Mid-frame load stays invisible until frame start.
    pulse_load(10'd100, 10'd100, 1'b0);
    run_vec("midload.new",  10'd100, 10'd100, 1'b1, 10'd0, 1'b0, 8'h00);
    run_vec("midload.old",  10'd310, 10'd230, 1'b1, 10'd0, 1'b1, 8'h3C);
    pulse_frame_start();
    run_vec("applied.org",  10'd100, 10'd100, 1'b1, 10'd0, 1'b1, 8'h3C);
    run_vec("applied.x1",   10'd101, 10'd100, 1'b1, 10'd1, 1'b1, 8'h3D);
    run_vec("applied.old",  10'd310, 10'd230, 1'b1, 10'd0, 1'b0, 8'h00);

    // Load on the frame-start cycle applies straight away; sprite clipped at the corner.
    pulse_load(10'd630, 10'd470, 1'b1);
    run_vec("clip.corner",  10'd639, 10'd479, 1'b1, 10'd189, 1'b1, 8'hF9);
    run_vec("clip.origin",  10'd630, 10'd470, 1'b1, 10'd0,   1'b1, 8'h3C);
    run_vec("clip.inact",   10'd639, 10'd479, 1'b0, 10'd0,   1'b0, 8'h00);
    pulse_frame_start();
    run_vec("nopend.keep",  10'd639, 10'd479, 1'b1, 10'd189, 1'b1, 8'hF9);

    // Async reset mid-line with a shadowed load outstanding.
    pulse_load(10'd50, 10'd50, 1'b0);
    @(negedge clk);
    x = 10'd639; y = 10'd479; active = 1'b1;
    repeat (4) @(negedge clk);
    check("prerst.valid", 32'(pixel_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("asyncrst.addr",  32'(numberaddr),  32'd0);
    check("asyncrst.valid", 32'(pixel_valid), 32'd0);
    check("asyncrst.pixel", 32'(pixel),       32'd0);
    @(negedge clk);
    rst_n = 1'b1; x = 10'd310; y = 10'd230; active = 1'b1;
    @(negedge clk);
    check("rel.c1.valid", 32'(pixel_valid), 32'd0);
    check("rel.c1.addr",  32'(numberaddr),  32'd0);
    @(negedge clk);
    check("rel.c2.valid", 32'(pixel_valid), 32'd0);
    @(negedge clk);
    check("rel.c3.valid", 32'(pixel_valid), 32'd1);
    check("rel.c3.pixel", 32'(pixel),       32'h3C);
    active = 1'b0; x = '0; y = '0;
    pulse_frame_start();
    run_vec("lostpend.rst", 10'd310, 10'd230, 1'b1, 10'd0, 1'b1, 8'h3C);
    run_vec("lostpend.50",  10'd50,  10'd50,  1'b1, 10'd0, 1'b0, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
